// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: captures floor calls and issues SCAN-ordered
// one-hot floor requests with a request strobe and a door dwell.
module elevator_call_scheduler #(
  parameter int STROBE_LEN   = 2,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [8:1] call_btn,
  input  logic [3:0] cur_floor,
  input  logic       arrived,
  input  logic       emergency_button,
  output logic [8:1] input_floor,
  output logic       in_floor,
  output logic [8:1] pending,
  output logic       busy,
  output logic       dir_up
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    TRAVEL,
    DWELL,
    HALT
  } state_t;

  localparam logic [7:0]  STB_LOAD = 8'(STROBE_LEN - 1);
  localparam logic [27:0] DWL_LOAD = 28'(DWELL_CYCLES - 1);

  state_t      state, state_n;
  logic [8:1]  btn_meta, btn_sync, btn_prev, rise_q;
  logic [3:0]  target, target_n;
  logic [7:0]  stb_cnt, stb_cnt_n;
  logic [27:0] dwl_cnt, dwl_cnt_n;
  logic [8:1]  input_floor_n, pending_n;
  logic        in_floor_n, dir_up_n, busy_n;
  logic        floor_ok, here_hit, hit_above, hit_below;
  logic [3:0]  lo_above, hi_below;

  function automatic logic [8:1] onehot(input logic [3:0] fl);
    logic [8:1] v;
    v = '0;
    for (int f = 1; f <= 8; f++) v[f] = (fl == 4'(f));
    return v;
  endfunction

  // Edges seen while halted are dropped so held buttons need a re-press.
  always_ff @(posedge CLK) begin
    if (reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      rise_q   <= '0;
    end else begin
      btn_meta <= call_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      rise_q   <= (state == HALT) ? '0 : (btn_sync & ~btn_prev);
    end
  end

  always_comb begin
    floor_ok  = (cur_floor >= 4'd1) && (cur_floor <= 4'd8);
    here_hit  = 1'b0;
    hit_above = 1'b0;
    hit_below = 1'b0;
    lo_above  = '0;
    hi_below  = '0;
    for (int f = 8; f >= 1; f--) begin
      if (pending[f] && (4'(f) > cur_floor)) begin
        hit_above = 1'b1;
        lo_above  = 4'(f);
      end
    end
    for (int f = 1; f <= 8; f++) begin
      if (pending[f] && (4'(f) < cur_floor)) begin
        hit_below = 1'b1;
        hi_below  = 4'(f);
      end
      if (pending[f] && (4'(f) == cur_floor)) here_hit = 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    target_n      = target;
    stb_cnt_n     = stb_cnt;
    dwl_cnt_n     = dwl_cnt;
    input_floor_n = input_floor;
    in_floor_n    = in_floor;
    dir_up_n      = dir_up;
    pending_n     = pending | rise_q;
    if (emergency_button) begin
      state_n       = HALT;
      pending_n     = '0;
      input_floor_n = '0;
      in_floor_n    = 1'b0;
      stb_cnt_n     = '0;
      dwl_cnt_n     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((pending != '0) && floor_ok) begin
            state_n = SETUP;
            if (here_hit) begin
              target_n = cur_floor;
            end else if (dir_up) begin
              if (hit_above) begin
                target_n = lo_above;
              end else begin
                target_n = hi_below;
                dir_up_n = 1'b0;
              end
            end else begin
              if (hit_below) begin
                target_n = hi_below;
              end else begin
                target_n = lo_above;
                dir_up_n = 1'b1;
              end
            end
            input_floor_n = onehot(target_n);
          end
        end
        SETUP: begin
          state_n    = STROBE;
          in_floor_n = 1'b1;
          stb_cnt_n  = STB_LOAD;
        end
        STROBE: begin
          if (stb_cnt == '0) begin
            state_n    = TRAVEL;
            in_floor_n = 1'b0;
          end else begin
            stb_cnt_n = stb_cnt - 8'd1;
          end
        end
        TRAVEL: begin
          if ((cur_floor == target) && arrived) begin
            state_n   = DWELL;
            pending_n = (pending | rise_q) & ~input_floor;
            dwl_cnt_n = DWL_LOAD;
          end
        end
        DWELL: begin
          // Door is open: a call for this floor is already being served.
          pending_n = pending | (rise_q & ~input_floor);
          if (dwl_cnt == '0) begin
            state_n       = IDLE;
            input_floor_n = '0;
          end else begin
            dwl_cnt_n = dwl_cnt - 28'd1;
          end
        end
        HALT: begin
          pending_n = pending;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n != IDLE) && (state_n != HALT);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      target      <= '0;
      stb_cnt     <= '0;
      dwl_cnt     <= '0;
      input_floor <= '0;
      in_floor    <= 1'b0;
      pending     <= '0;
      busy        <= 1'b0;
      dir_up      <= 1'b1;
    end else begin
      state       <= state_n;
      target      <= target_n;
      stb_cnt     <= stb_cnt_n;
      dwl_cnt     <= dwl_cnt_n;
      input_floor <= input_floor_n;
      in_floor    <= in_floor_n;
      pending     <= pending_n;
      busy        <= busy_n;
      dir_up      <= dir_up_n;
    end
  end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Upstream stage of the elevator controller. Captures asynchronous floor-call button presses into a pending-call register, chooses the next target floor with a SCAN (keep-direction) policy, and presents it to the controller. It drives the controller's one-hot floor-request bus and its `in_floor` request strobe. It retires a call once the controller reports arrival at that floor, then holds for a door dwell time before issuing the next call.

## Interface
- `STROBE_LEN`, default 2: cycles `in_floor` is held high per issued request (≥1).
- `DWELL_CYCLES`, default 50_000_000: door dwell after arrival before the next issue (≥1). The counter is 28 bits wide.
- `CLK`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `call_btn`  in  8 `[8:1]`  raw call buttons, asynchronous, bit n = floor n (floor 1 = ground).
- `cur_floor`  in  4  controller's current floor, binary 1..8.
- `arrived`  in  1  controller's at-floor/stay indication (level).
- `emergency_button`  in  1  emergency stop (level).
- `input_floor`  out  8 `[8:1]`  one-hot target floor to the controller; all-zero when no target.
- `in_floor`  out  1  request strobe; `input_floor` is stable whenever it is high.
- `pending`  out  8 `[8:1]`  outstanding calls.
- `busy`  out  1  high in any state other than IDLE and HALT.
- `dir_up`  out  1  current SCAN direction (1 = up).

## Operation
- Input path: `call_btn` passes through a 2-FF synchroniser, then rising-edge detection. A detected edge sets the matching `pending` bit.
- States: IDLE, SETUP, STROBE, TRAVEL, DWELL, HALT.
- **IDLE**
  - If `pending != 0` and `cur_floor` is in 1..8: latch `target`, update `dir_up`, go to SETUP.
  - If `cur_floor` is invalid: stay in IDLE.
- **Target selection**, evaluated in IDLE only, first match wins:
  1. `pending[cur_floor]`: target = `cur_floor`.
  2. `dir_up = 1`: lowest pending floor above `cur_floor`. Otherwise the highest pending floor below, and `dir_up` clears to 0.
  3. `dir_up = 0`: highest pending floor below. Otherwise the lowest pending floor above, and `dir_up` sets to 1.
- **SETUP** (1 cycle): `input_floor` = one-hot(`target`), `in_floor` = 0. Go to STROBE.
- **STROBE** (`STROBE_LEN` cycles): `in_floor` = 1. Then go to TRAVEL with `in_floor` = 0.
- **TRAVEL**: wait for `cur_floor == target` and `arrived = 1` in the same cycle. On that edge, clear `pending[target]` and load the dwell counter; go to DWELL.
- **DWELL**: count `DWELL_CYCLES`. On expiry, set `input_floor` = 0 and go to IDLE.
- `input_floor` holds its one-hot value from SETUP through the end of DWELL.
- `emergency_button` high, from any state, on the next edge:
  - go to HALT;
  - clear `pending`, `input_floor`, `in_floor` and the counters.
- **HALT**:
  - calls are ignored and the synchroniser keeps running;
  - exit to IDLE on the first cycle `emergency_button` is low;
  - buttons already held down at exit do not register until released and pressed again.
- Simultaneous events:
  - A press for `target` in the arrival cycle or during DWELL is discarded, because the door is open.
  - Presses for other floors during SETUP, STROBE, TRAVEL or DWELL set `pending` normally. They do not retarget an in-flight request.
  - Several edges in one cycle set all of their bits.

## Timing
- Reset values: `input_floor` = 0, `in_floor` = 0, `pending` = 0, `busy` = 0, `dir_up` = 1, state = IDLE, counters = 0.
- Reset has priority over emergency and over every other input.
- Press to pending: a button sampled high at edge k gives a `pending` bit set after edge k+3.
- Pending to request:
  - IDLE with pending at edge p gives SETUP outputs after edge p+1.
  - `in_floor` rises after edge p+2 and falls after edge p+2+`STROBE_LEN`.
  - `input_floor` is therefore valid at least one full cycle before `in_floor` rises.
- Arrival to next issue:
  - Arrival sampled at edge a: `pending` bit cleared after a.
  - IDLE is re-entered after a+`DWELL_CYCLES`.
  - The next SETUP follows at the earliest one cycle later.
- `busy` is registered, so it is high exactly while the state is SETUP, STROBE, TRAVEL or DWELL.

## Test plan
- **Reset**: assert `reset` for 2 cycles mid-TRAVEL.
  - Expect all outputs at reset values and `pending` = 0.
  - Expect no `in_floor` pulse afterward.
- **Single call**: `cur_floor` = 1, press floor 4, `STROBE_LEN` = 2.
  - Expect `pending` = 8'b0000_1000 3 cycles after the press.
  - Expect `input_floor` = 8'b0000_1000 one cycle later, then `in_floor` high for 2 cycles.
  - Then drive `cur_floor` = 4 with `arrived` = 1: expect `pending` = 0, with `input_floor` held for `DWELL_CYCLES` (set 10) before it clears.
- **SCAN order**: `dir_up` = 1, `cur_floor` = 3, pending floors {2, 5, 7}.
  - Expect issue order 5, 7, 2.
  - Expect `dir_up` to fall to 0 when 2 is selected.
- **Same-floor call**: `cur_floor` = 6, press 6 in IDLE.
  - Expect target 6 issued immediately.
  - Re-pressing 6 during DWELL leaves `pending[6]` = 0.
- **Emergency**: pending {3, 8}, assert `emergency_button` in STROBE.
  - Expect `in_floor` = 0, `input_floor` = 0, `pending` = 0 on the next edge.
  - A press during HALT is ignored.
  - After release, a fresh press of 8 is served normally.
- **Invalid floor / simultaneous press**: `cur_floor` = 0 with pending set.
  - Expect IDLE held and `busy` = 0.
  - Then `cur_floor` = 2 and floors 1 and 8 pressed in the same cycle: both bits set, target 8 issued first with `dir_up` = 1.
